// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator machine.
// Owns PC, IR, MAR, MBR and AC and drives the main-memory address and write port.
module control_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] ac,
    output logic              halted,
    output logic              instr_done,
    output logic              illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_IR,
        S_DECODE,
        S_READ,
        S_MBR,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] mar_reg, mar_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [DATA_W-1:0] ac_reg, ac_next;
    logic [DATA_W-1:0] mbr_reg, mbr_next;

    logic              we_raw;
    logic              done_raw;
    logic              ill_raw;

    logic [3:0]        opcode;
    logic [1:0]        skip_sel;
    logic              ac_neg;
    logic              ac_zero;
    logic              skip_taken;

    assign opcode     = ir_reg[DATA_W-1 -: 4];
    assign skip_sel   = ir_reg[DATA_W-5 -: 2];
    assign ac_neg     = ac_reg[DATA_W-1];
    assign ac_zero    = (ac_reg == '0);
    assign skip_taken = ((skip_sel == 2'b00) && ac_neg) ||
                        ((skip_sel == 2'b01) && ac_zero) ||
                        ((skip_sel == 2'b10) && !ac_neg && !ac_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
            ac_reg    <= '0;
            mar_reg   <= '0;
            mbr_reg   <= '0;
        end else if (!stall) begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            ac_reg    <= ac_next;
            mar_reg   <= mar_next;
            mbr_reg   <= mbr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        ac_next    = ac_reg;
        mar_next   = mar_reg;
        mbr_next   = mbr_reg;
        we_raw     = 1'b0;
        done_raw   = 1'b0;
        ill_raw    = 1'b0;

        case (state_reg)
            S_FETCH: state_next = S_IR;
            S_IR: begin
                ir_next    = mem_rdata;
                pc_next    = pc_reg + 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                mar_next = ir_reg[ADDR_W-1:0];
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUBT: state_next = S_READ;
                    OP_STORE: state_next = S_WRITE;
                    OP_JUMP: begin
                        pc_next    = ir_reg[ADDR_W-1:0];
                        done_raw   = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_CLEAR: begin
                        ac_next    = '0;
                        done_raw   = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_SKIP: begin
                        // pc already points past the Skipcond; a skip steps over one more word
                        if (skip_taken) begin
                            pc_next = pc_reg + 1'b1;
                        end
                        done_raw   = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_HALT: begin
                        done_raw   = 1'b1;
                        state_next = S_HALT;
                    end
                    default: begin
                        ill_raw    = 1'b1;
                        done_raw   = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_READ: state_next = S_MBR;
            S_MBR: begin
                mbr_next   = mem_rdata;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD: ac_next = mbr_reg;
                    OP_ADD:  ac_next = ac_reg + mbr_reg;
                    OP_SUBT: ac_next = ac_reg - mbr_reg;
                    default: ac_next = ac_reg;
                endcase
                done_raw   = 1'b1;
                state_next = S_FETCH;
            end
            S_WRITE: begin
                we_raw     = 1'b1;
                done_raw   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Pulses and the write strobe are suppressed while nothing is allowed to advance.
    assign mem_we     = we_raw & ~stall & ~reset;
    assign instr_done = done_raw & ~stall & ~reset;
    assign illegal_op = ill_raw & ~stall & ~reset;

    assign mem_addr   = ((state_reg == S_FETCH) || (state_reg == S_IR)) ? pc_reg : mar_reg;
    assign mem_wdata  = ac_reg;
    assign pc         = pc_reg;
    assign ir         = ir_reg;
    assign ac         = ac_reg;
    assign halted     = (state_reg == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed programs plus a random instruction stream,
// checked against an instruction-level model of the accumulator machine.
module tb_control_sequencer;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int MEM_N = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] ac;
    logic          halted;
    logic          instr_done;
    logic          illegal_op;

    control_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .pc         (pc),
        .ir         (ir),
        .ac         (ac),
        .halted     (halted),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Main memory with registered read data.
    logic [DW-1:0] mem [MEM_N];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Architectural reference state.
    int ref_mem [MEM_N];
    int ref_pc;
    int ref_ac;
    int ref_halted;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges  = 0;
    int n_done   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        n_edges++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        mem[a]     <= d[DW-1:0];
        ref_mem[a]  = d & 'hFFFF;
    endtask

    task automatic ref_reset();
        ref_pc     = 0;
        ref_ac     = 0;
        ref_halted = 0;
        n_edges    = 0;
        n_done     = 0;
    endtask

    // Executes one instruction at the ISA level and reports its nominal cycle count.
    task automatic ref_step(output int lat, output int ill, output int wa);
        int instr, op, a, sac, cond, skip;
        instr  = ref_mem[ref_pc];
        op     = instr / 4096;
        a      = instr % MEM_N;
        ref_pc = (ref_pc + 1) % MEM_N;
        sac    = (ref_ac >= 32768) ? ref_ac - 65536 : ref_ac;
        ill    = 0;
        wa     = -1;
        lat    = 3;
        case (op)
            1: begin ref_ac = ref_mem[a]; lat = 6; end
            3: begin ref_ac = (ref_ac + ref_mem[a]) % 65536; lat = 6; end
            4: begin ref_ac = (ref_ac - ref_mem[a] + 65536) % 65536; lat = 6; end
            2: begin ref_mem[a] = ref_ac; wa = a; lat = 4; end
            9: ref_pc = a;
            10: ref_ac = 0;
            8: begin
                cond = (instr / 1024) % 4;
                skip = ((cond == 0) && (sac < 0)) || ((cond == 1) && (sac == 0)) ||
                       ((cond == 2) && (sac > 0));
                if (skip != 0) ref_pc = (ref_pc + 1) % MEM_N;
            end
            7: ref_halted = 1;
            default: ill = 1;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_done", 32'(instr_done), 0);
        chk("rst_ill", 32'(illegal_op), 0);
        tick();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ac", 32'(ac), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_halted", 32'(halted), 0);
        reset = 1'b0;
        ref_reset();
    endtask

    // Runs one instruction starting in its fetch cycle, optionally stalling at a given cycle.
    task automatic run_instr(input string tag, input int stall_at, input int stall_len, output int cyc);
        int lat, ill, wa, exp_lat, ill_cnt;
        bit we_seen, done, glitch;
        ref_step(lat, ill, wa);
        exp_lat = lat + ((stall_at >= 1 && stall_at <= lat) ? stall_len : 0);
        cyc = 0; done = 0; ill_cnt = 0; we_seen = 0; glitch = 0;
        while (!done && cyc < 64) begin
            cyc++;
            if (cyc == stall_at && stall_len > 0) begin
                for (int k = 0; k < stall_len; k++) begin
                    stall = 1'b1;
                    #1;
                    if (instr_done || illegal_op || mem_we) glitch = 1;
                    tick();
                    cyc++;
                end
                stall = 1'b0;
                #1;
            end
            if (mem_we) we_seen = 1;
            if (illegal_op) ill_cnt++;
            if (instr_done) begin
                done = 1;
                n_done++;
            end
            tick();
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_pc"}, 32'(pc), ref_pc);
        chk({tag, "_ac"}, 32'(ac), ref_ac);
        chk({tag, "_halted"}, 32'(halted), ref_halted);
        chk({tag, "_ill"}, ill_cnt, ill);
        chk({tag, "_we"}, 32'(we_seen), (wa >= 0) ? 1 : 0);
        if (wa >= 0) chk({tag, "_mem"}, 32'(mem[wa]), ref_mem[wa]);
        if (stall_len > 0) chk({tag, "_stallq"}, 32'(glitch), 0);
        $display("[%0t] %s ir=%h pc=%h ac=%h cycles=%0d", $time, tag, ir, pc, ac, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, op, a, s_at, s_len, hold_bad;
        for (int i = 0; i < MEM_N; i++) begin
            int r;
            r = int'($urandom_range(0, 65535));
            mem[i]     <= r[DW-1:0];
            ref_mem[i]  = r;
        end
        tick();
        do_reset();

        // Load / Add / Store / Halt program.
        poke(0, 'h1010); poke(1, 'h3011); poke(2, 'h2012); poke(3, 'h7000);
        poke('h10, 'h0005); poke('h11, 'hFFFE);
        run_instr("p1_load", 0, 0, cyc);
        run_instr("p1_add", 0, 0, cyc);
        run_instr("p1_store", 0, 0, cyc);
        run_instr("p1_halt", 0, 0, cyc);
        chk("p1_m12", 32'(mem['h12]), 'h0003);
        chk("p1_ac_const", 32'(ac), 'h0003);
        chk("p1_edges", n_edges, 19);
        chk("p1_pulses", n_done, 4);
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_done || !halted) hold_bad++;
        end
        chk("halt_hold", hold_bad, 0);
        chk("halt_pc", 32'(pc), 4);

        // Subtract wrapping below zero, then Skipcond on a negative ac.
        do_reset();
        poke(0, 'h1010); poke(1, 'h4011); poke(2, 'h8000);
        poke('h10, 'h0000); poke('h11, 'h0001);
        run_instr("p2_load", 0, 0, cyc);
        run_instr("p2_subt", 0, 0, cyc);
        chk("p2_ac_const", 32'(ac), 'hFFFF);
        run_instr("p2_skipneg", 0, 0, cyc);
        chk("p2_pc_const", 32'(pc), 4);

        // Skipcond variants, Jump to the last address, illegal opcode there, pc wrap.
        do_reset();
        poke(0, 'h8400);
        run_instr("sk_zero", 0, 0, cyc);
        chk("sk_zero_pc", 32'(pc), 2);
        poke(2, 'h8800);
        run_instr("sk_pos", 0, 0, cyc);
        chk("sk_pos_pc", 32'(pc), 3);
        poke(3, 'h1020); poke('h20, 'h0001);
        run_instr("sk_load1", 0, 0, cyc);
        poke(4, 'h8C00);
        run_instr("sk_never", 0, 0, cyc);
        chk("sk_never_pc", 32'(pc), 5);
        poke(5, 'h9FFF); poke('hFFF, 'hF000);
        run_instr("jmp_last", 0, 0, cyc);
        chk("jmp_pc", 32'(pc), 'hFFF);
        run_instr("ill_wrap", 0, 0, cyc);
        chk("ill_pc", 32'(pc), 0);
        chk("ill_ac", 32'(ac), 1);
        run_instr("after_wrap", 0, 0, cyc);

        // Five-cycle stall during the MBR cycle of an Add.
        do_reset();
        poke(0, 'h1010); poke(1, 'h3011); poke('h10, 'h0005); poke('h11, 'hFFFE);
        run_instr("st_load", 0, 0, cyc);
        run_instr("st_add", 5, 5, cyc);
        chk("st_lat_const", cyc, 11);
        chk("st_ac_const", 32'(ac), 'h0003);

        // Reset arriving in the write cycle of a Store.
        do_reset();
        poke(0, 'h1010); poke(1, 'h2020); poke('h10, 'hABCD); poke('h20, 'h1234);
        run_instr("rw_load", 0, 0, cyc);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("rw_we", 32'(mem_we), 0);
        chk("rw_done", 32'(instr_done), 0);
        tick();
        chk("rw_pc", 32'(pc), 0);
        chk("rw_ac", 32'(ac), 0);
        chk("rw_mem", 32'(mem['h20]), 'h1234);
        reset = 1'b0;
        ref_reset();
        run_instr("rw_restart", 0, 0, cyc);

        // Reset out of the halt state restarts at address 0.
        poke(2, 'h7000);
        run_instr("rh_store", 0, 0, cyc);
        run_instr("rh_halt", 0, 0, cyc);
        do_reset();
        run_instr("rh_restart", 0, 0, cyc);

        // Random instruction stream with occasional stalls.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 15));
            if (op == 7) op = 3;
            a = int'($urandom_range(0, MEM_N - 1));
            poke(ref_pc, op * 4096 + a);
            if ($urandom_range(0, 3) == 0) begin
                s_at  = int'($urandom_range(1, 6));
                s_len = int'($urandom_range(1, 3));
            end else begin
                s_at  = 0;
                s_len = 0;
            end
            run_instr($sformatf("rnd%0d", n), s_at, s_len, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
